// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid buffer between pipeline stages.
//
// Carries a generic payload plus register-address, T_new and forwarding-data
// sideband. in_ready comes only from registered occupancy, so there is no
// combinational path from out_ready back to in_ready. T_new is decremented
// (saturating) on entry, and do_rel is set when the producer finishes this
// cycle. An empty stage presents an all-zero nop on every out_* field.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-low reset
//   in_valid / in_ready        upstream handshake
//   in_payload, in_ura,
//   in_tnew, in_do, in_do_rel  entry fields
//   flush                      drop all held entries
//   out_valid / out_ready      downstream handshake
//   out_payload, out_ura,
//   out_tnew, out_do,
//   out_do_rel                 head entry fields (zero when out_valid=0)
//   stall_cnt                  saturating count of back-pressured cycles
module pipe_stage_reg #(
    parameter int PAYLOAD_W = 128,
    parameter int NUM_URA   = 5,
    parameter int URA_W     = 7,
    parameter int TNEW_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_W-1:0]     in_payload,
    input  logic [NUM_URA*URA_W-1:0] in_ura,
    input  logic [TNEW_W-1:0]        in_tnew,
    input  logic [31:0]              in_do,
    input  logic                     in_do_rel,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_W-1:0]     out_payload,
    output logic [NUM_URA*URA_W-1:0] out_ura,
    output logic [TNEW_W-1:0]        out_tnew,
    output logic [31:0]              out_do,
    output logic                     out_do_rel,
    output logic [15:0]              stall_cnt
);

    typedef struct packed {
        logic [PAYLOAD_W-1:0]     payload;
        logic [NUM_URA*URA_W-1:0] ura;
        logic [TNEW_W-1:0]        tnew;
        logic [31:0]              data;
        logic                     do_rel;
    } entry_t;

    // slot[0] is always the head; slot[1] is the skid entry.
    entry_t     slot [2];
    entry_t     in_entry;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_ready  = ~count[1];
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        in_entry         = '0;
        in_entry.payload = in_payload;
        in_entry.ura     = in_ura;
        in_entry.data    = in_do;
        // Saturating decrement: a result already due stays due.
        in_entry.tnew    = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
        // Producer completes this cycle, so the data is ready for forwarding.
        in_entry.do_rel  = in_do_rel | (in_tnew == TNEW_W'(1));
    end

    // Occupancy and stall counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= 2'd0;
            stall_cnt <= 16'd0;
        end else if (flush) begin
            count     <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Entry storage; contents are don't-care whenever count says empty.
    always_ff @(posedge clk) begin
        case ({push, pop})
            2'b10: slot[count[0]] <= in_entry;
            2'b01: slot[0]        <= slot[1];
            // Push and pop together only happen at count 1 (push needs
            // count<2, pop needs count>0): the new entry becomes the head.
            2'b11: slot[0]        <= in_entry;
            default: ;
        endcase
    end

    // Bubbles read as all-zero nops.
    always_comb begin
        out_payload = '0;
        out_ura     = '0;
        out_tnew    = '0;
        out_do      = '0;
        out_do_rel  = 1'b0;
        if (out_valid) begin
            out_payload = slot[0].payload;
            out_ura     = slot[0].ura;
            out_tnew    = slot[0].tnew;
            out_do      = slot[0].data;
            out_do_rel  = slot[0].do_rel;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg: stream, backpressure, T_new
// handling, flush, reset mid-operation and stall counter saturation.
module tb_pipe_stage_reg;

    localparam int PW = 128;
    localparam int UW = 35;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_payload;
    logic [UW-1:0] in_ura;
    logic [TW-1:0] in_tnew;
    logic [31:0]   in_do;
    logic          in_do_rel;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_payload;
    logic [UW-1:0] out_ura;
    logic [TW-1:0] out_tnew;
    logic [31:0]   out_do;
    logic          out_do_rel;
    logic [15:0]   stall_cnt;

    int tests = 0;
    int fails = 0;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_payload(in_payload), .in_ura(in_ura), .in_tnew(in_tnew),
        .in_do(in_do), .in_do_rel(in_do_rel), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_payload(out_payload), .out_ura(out_ura), .out_tnew(out_tnew),
        .out_do(out_do), .out_do_rel(out_do_rel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [127:0] p, input logic [1:0] t, input logic rel);
        in_valid   = v;
        in_payload = p;
        in_tnew    = t;
        in_do_rel  = rel;
        in_ura     = UW'(p * 3);
        in_do      = 32'hA000 + p[31:0];
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_payload = '0; in_ura = '0; in_tnew = '0; in_do = '0; in_do_rel = 1'b0;
        tick(); tick();

        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_payload", out_payload, 0);
        chk("rst_do", out_do, 0);
        reset = 1'b1;

        // stream: one entry per cycle, 1-cycle latency
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 128'(i), 2'd2, 1'b0);
            tick();
            chk("str_valid", out_valid, 1);
            chk("str_payload", out_payload, 128'(i));
            chk("str_tnew", out_tnew, 1);
            chk("str_ura", out_ura, 128'(i * 3));
            chk("str_do", out_do, 128'(32'hA000 + i));
            chk("str_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("str_drain", out_valid, 0);
        chk("str_bubble", out_payload, 0);
        chk("str_stall", stall_cnt, 0);

        // backpressure
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 128'hA, 2'd2, 1'b0);
        tick();
        chk("bp_a_ready", in_ready, 1);
        chk("bp_a_stall", stall_cnt, 0);
        drive(1'b1, 128'hB, 2'd2, 1'b0);
        tick();
        chk("bp_b_ready", in_ready, 0);
        chk("bp_b_stall", stall_cnt, 1);
        drive(1'b1, 128'hC, 2'd2, 1'b0);
        tick();
        chk("bp_c_ready", in_ready, 0);
        chk("bp_c_stall", stall_cnt, 2);
        chk("bp_head_a", out_payload, 128'hA);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_head_b", out_payload, 128'hB);
        chk("bp_ready_up", in_ready, 1);
        chk("bp_stall_hold", stall_cnt, 2);
        tick();
        chk("bp_empty", out_valid, 0);

        // T_new saturation and do_rel generation
        out_ready = 1'b1;
        drive(1'b1, 128'h10, 2'd0, 1'b0);
        tick();
        chk("tn0_tnew", out_tnew, 0);
        chk("tn0_rel", out_do_rel, 0);
        drive(1'b1, 128'h11, 2'd1, 1'b0);
        tick();
        chk("tn1_tnew", out_tnew, 0);
        chk("tn1_rel", out_do_rel, 1);
        drive(1'b1, 128'h12, 2'd3, 1'b0);
        tick();
        chk("tn3_tnew", out_tnew, 2);
        chk("tn3_rel", out_do_rel, 0);
        drive(1'b1, 128'h13, 2'd3, 1'b1);
        tick();
        chk("relin_rel", out_do_rel, 1);
        in_valid = 1'b0;
        tick();

        // flush with two held entries and a push offered
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 128'h21, 2'd2, 1'b0);
        tick();
        drive(1'b1, 128'h22, 2'd2, 1'b0);
        tick();
        chk("fl_full", in_ready, 0);
        chk("fl_pre_stall", stall_cnt, 1);
        drive(1'b1, 128'h23, 2'd2, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_payload", out_payload, 0);
        chk("fl_tnew", out_tnew, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_stall", stall_cnt, 1);

        // reset mid-operation: count 2, stall_cnt 5
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 128'h31, 2'd2, 1'b0);
        tick();
        drive(1'b1, 128'h32, 2'd2, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("rm_pre_stall", stall_cnt, 5);
        chk("rm_pre_full", in_ready, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rm_valid", out_valid, 0);
        chk("rm_stall", stall_cnt, 0);
        chk("rm_payload", out_payload, 0);
        chk("rm_ready", in_ready, 1);

        // stall counter saturation, then push+pop at count 1
        out_ready = 1'b0;
        drive(1'b1, 128'h41, 2'd2, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (65540) tick();
        chk("sat_stall", stall_cnt, 16'hFFFF);
        out_ready = 1'b1;
        drive(1'b1, 128'h77, 2'd2, 1'b0);
        tick();
        chk("pp_valid", out_valid, 1);
        chk("pp_payload", out_payload, 128'h77);
        chk("pp_ready", in_ready, 1);
        chk("pp_stall", stall_cnt, 16'hFFFF);
        in_valid = 1'b0;
        tick();
        chk("pp_drain", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
